lsu_arbiter: RTL and testbench
==============================

LSU_ARBITER -- requirements
Module: lsu_arbiter

Interface
REQ-001 The block SHALL have parameter RD_LAT, default 1: cycles from LSU address launch to load-data sample, legal 0..7.
REQ-002 The block SHALL have i_clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have i_rst, input, 1: reset, asynchronous and active-low.
REQ-004 For each requester k in {0,1} (0 = core, 1 = loader/debug), the block SHALL have i_mk_valid, input, 1: request pending.
REQ-005 For each requester k, the block SHALL have the following inputs: i_mk_addr (32), i_mk_wdata (32), i_mk_wren (1, 1 = store) and i_mk_sel_mod (3: [1:0] 00 byte, 01 half, 10 word; [2] unsigned).
REQ-006 For each requester k, the block SHALL have o_mk_ready, output, 1: request accepted this cycle.
REQ-007 For each requester k, the block SHALL have o_mk_rsp_valid, output, 1: one-cycle response pulse.
REQ-008 For each requester k, the block SHALL have o_mk_rsp_data, output, 32: load data, or 0 for stores.
REQ-009 The block SHALL have the following LSU-side outputs: o_lsu_addr (32), o_lsu_st_data (32), o_lsu_wren (1) and o_lsu_sel_mod (3).
REQ-010 The block SHALL have i_lsu_ld_data, input, 32: LSU load result.
REQ-011 The block SHALL have o_busy, output, 1: state != IDLE.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, ACCESS, WAIT, RESP.
REQ-013 IDLE: if either valid is high, the block SHALL select a winner, assert the winner's o_mk_ready combinationally in that cycle, latch its addr/wdata/wren/sel_mod and its id, and go to ACCESS; the loser's ready SHALL stay 0.
REQ-014 A handshake SHALL occur only when valid and ready are both 1; ready SHALL be 0 in every state other than IDLE.
REQ-015 ACCESS: LSU outputs SHALL be driven from the latched request, and o_lsu_wren SHALL equal the latched wren for exactly this one cycle; next state SHALL be WAIT if RD_LAT > 0, else RESP.
REQ-016 WAIT: o_lsu_addr and o_lsu_sel_mod SHALL hold, o_lsu_wren = 0, and a 3-bit counter SHALL count RD_LAT-1 down to 0 before going to RESP.
REQ-017 i_lsu_ld_data SHALL be registered on the last cycle before RESP.
REQ-018 RESP: the block SHALL pulse o_mk_rsp_valid for the latched id only, with rsp_data = registered load data (0 if store), then return to IDLE.
REQ-019 Per-access latency SHALL be: handshake cycle N, response at cycle N+2+RD_LAT; throughput SHALL be one access per 3+RD_LAT cycles.
REQ-020 In IDLE and RESP, o_lsu_wren SHALL be 0, and o_lsu_addr/st_data/sel_mod SHALL hold their last values.
REQ-021 Both valids high simultaneously SHALL be resolved per REQ-027/REQ-028; a valid arriving while busy SHALL wait, with no drop or reordering within a requester.
REQ-022 o_mk_rsp_data for the non-responding requester SHALL hold its previous value, with rsp_valid = 0.

Reset
REQ-023 While i_rst = 0, the state SHALL be IDLE, and all outputs, latches, the counter and rsp_data SHALL be 0.
REQ-024 The round-robin pointer SHALL reset to favour m0.
REQ-025 Reset asserted mid-transaction SHALL abort it immediately; no rsp_valid SHALL be emitted for it, and o_lsu_wren SHALL drop to 0 asynchronously.
REQ-026 After deassertion, the first handshake SHALL be possible in the first IDLE cycle.

Configuration
REQ-027 With macro LSU_ARB_RR_EN defined, arbitration SHALL be round-robin: the last-granted requester has lowest priority, and the pointer updates on every grant.
REQ-028 With LSU_ARB_RR_EN undefined, arbitration SHALL be fixed priority (m0 always wins), and the pointer logic SHALL be absent.

Verification
REQ-029 After reset, the bench SHALL check that all outputs are 0 and o_busy = 0; an m0 word store (addr 0x0000_0010, data 0xDEAD_BEEF) -> o_lsu_wren = 1 for exactly one cycle with matching addr/data, then m0 rsp_valid with data 0.
REQ-030 The bench SHALL cover an m1 byte load (addr 0x0000_0904) with LSU returning 0x0000_00A5, RD_LAT = 1 -> m1 rsp_valid at handshake + 3, data 0x0000_00A5, and m0 rsp_valid = 0.
REQ-031 The bench SHALL hold both valid for 4 transactions with LSU_ARB_RR_EN -> grant order m0, m1, m0, m1; without the macro -> m0 four times, and m1 ready never asserts.
REQ-032 The bench SHALL raise m1 valid during m0's WAIT -> m1 ready = 0 until IDLE, then m1 is granted in the first IDLE cycle.
REQ-033 The bench SHALL assert reset during WAIT of an m0 load -> no rsp_valid, state IDLE and outputs 0; a post-reset m0 load of 0x0000_0000 completes normally.
REQ-034 The bench SHALL run with RD_LAT = 0 -> the WAIT state is never entered, and the response arrives at handshake + 2.

Source files
------------

// File: rtl/lsu_arbiter.sv
// Two-requester arbiter in front of a single LSU port; one access in flight at a time.
// Define LSU_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
`timescale 1ns/1ps
module lsu_arbiter #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_m0_valid,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic        i_m0_wren,
    input  logic [2:0]  i_m0_sel_mod,
    output logic        o_m0_ready,
    output logic        o_m0_rsp_valid,
    output logic [31:0] o_m0_rsp_data,
    input  logic        i_m1_valid,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic        i_m1_wren,
    input  logic [2:0]  i_m1_sel_mod,
    output logic        o_m1_ready,
    output logic        o_m1_rsp_valid,
    output logic [31:0] o_m1_rsp_data,
    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_lsu_st_data,
    output logic        o_lsu_wren,
    output logic [2:0]  o_lsu_sel_mod,
    input  logic [31:0] i_lsu_ld_data,
    output logic        o_busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam bit         HAS_WAIT = (RD_LAT != 0);
    localparam logic [2:0] CNT_INIT = HAS_WAIT ? 3'(RD_LAT - 1) : 3'd0;

    state_t      state_q, state_d;
    logic        id_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        wren_q;
    logic [2:0]  sel_q;
    logic [2:0]  cnt_q;
    logic [31:0] rsp_data0_q;
    logic [31:0] rsp_data1_q;
    logic        gnt0;
    logic        gnt1;
    logic        hs;
    logic        sample;

`ifdef LSU_ARB_RR_EN
    logic rr_last_q;  // 1 when m1 was granted most recently

    always_comb begin
        gnt0 = i_m0_valid;
        gnt1 = i_m1_valid;
        if (i_m0_valid && i_m1_valid) begin
            gnt0 = rr_last_q;
            gnt1 = !rr_last_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rr_last_q <= 1'b1;
        end else if (hs) begin
            rr_last_q <= o_m1_ready;
        end
    end
`else
    always_comb begin
        gnt0 = i_m0_valid;
        gnt1 = i_m1_valid && !i_m0_valid;
    end
`endif

    // Ready is gated by reset so nothing can be accepted while the block is held in reset.
    assign o_m0_ready = (state_q == IDLE) && i_rst && gnt0;
    assign o_m1_ready = (state_q == IDLE) && i_rst && gnt1;
    assign hs         = o_m0_ready || o_m1_ready;

    assign sample = ((state_q == ACCESS) && !HAS_WAIT) ||
                    ((state_q == WAIT) && (cnt_q == 3'd0));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = ACCESS;
            ACCESS:  state_d = HAS_WAIT ? WAIT : RESP;
            WAIT:    if (cnt_q == 3'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            id_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wren_q      <= 1'b0;
            sel_q       <= '0;
            cnt_q       <= '0;
            rsp_data0_q <= '0;
            rsp_data1_q <= '0;
        end else begin
            if (hs) begin
                id_q    <= o_m1_ready;
                addr_q  <= o_m1_ready ? i_m1_addr    : i_m0_addr;
                wdata_q <= o_m1_ready ? i_m1_wdata   : i_m0_wdata;
                wren_q  <= o_m1_ready ? i_m1_wren    : i_m0_wren;
                sel_q   <= o_m1_ready ? i_m1_sel_mod : i_m0_sel_mod;
            end
            if (state_q == ACCESS) begin
                cnt_q <= CNT_INIT;
            end else if ((state_q == WAIT) && (cnt_q != 3'd0)) begin
                cnt_q <= cnt_q - 3'd1;
            end
            // Load data lands straight in the owner's response register; stores answer 0.
            if (sample) begin
                if (id_q) begin
                    rsp_data1_q <= wren_q ? 32'h0 : i_lsu_ld_data;
                end else begin
                    rsp_data0_q <= wren_q ? 32'h0 : i_lsu_ld_data;
                end
            end
        end
    end

    assign o_lsu_addr     = addr_q;
    assign o_lsu_st_data  = wdata_q;
    assign o_lsu_sel_mod  = sel_q;
    assign o_lsu_wren     = (state_q == ACCESS) && wren_q;
    assign o_m0_rsp_valid = (state_q == RESP) && !id_q;
    assign o_m1_rsp_valid = (state_q == RESP) && id_q;
    assign o_m0_rsp_data  = rsp_data0_q;
    assign o_m1_rsp_data  = rsp_data1_q;
    assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_lsu_arbiter.sv
// Scoreboard bench for lsu_arbiter: main instance with RD_LAT=1, second instance with RD_LAT=0.
`timescale 1ns/1ps
module tb_lsu_arbiter;
    localparam int RD = 1;

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_valid, m0_wren, m1_valid, m1_wren;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, ld_data;
    logic [2:0]  m0_sel, m1_sel;
    logic        m0_ready, m0_rsp_valid, m1_ready, m1_rsp_valid, lsu_wren, busy;
    logic [31:0] m0_rsp_data, m1_rsp_data, lsu_addr, lsu_st_data;
    logic [2:0]  lsu_sel;
    logic        z_m0_valid, z_m1_valid;
    logic        z_m0_ready, z_m0_rsp_valid, z_m1_ready, z_m1_rsp_valid, z_lsu_wren, z_busy;
    logic [31:0] z_m0_rsp_data, z_m1_rsp_data, z_lsu_addr, z_lsu_st_data;
    logic [2:0]  z_lsu_sel;

    int   cyc = 0;
    int   vec_cnt = 0;
    int   err_cnt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_arbiter #(.RD_LAT(RD)) u_dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_m0_valid(m0_valid), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
        .i_m0_wren(m0_wren), .i_m0_sel_mod(m0_sel),
        .o_m0_ready(m0_ready), .o_m0_rsp_valid(m0_rsp_valid), .o_m0_rsp_data(m0_rsp_data),
        .i_m1_valid(m1_valid), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
        .i_m1_wren(m1_wren), .i_m1_sel_mod(m1_sel),
        .o_m1_ready(m1_ready), .o_m1_rsp_valid(m1_rsp_valid), .o_m1_rsp_data(m1_rsp_data),
        .o_lsu_addr(lsu_addr), .o_lsu_st_data(lsu_st_data), .o_lsu_wren(lsu_wren),
        .o_lsu_sel_mod(lsu_sel), .i_lsu_ld_data(ld_data), .o_busy(busy)
    );

    lsu_arbiter #(.RD_LAT(0)) u_dut_lat0 (
        .i_clk(clk), .i_rst(rst_n),
        .i_m0_valid(z_m0_valid), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
        .i_m0_wren(m0_wren), .i_m0_sel_mod(m0_sel),
        .o_m0_ready(z_m0_ready), .o_m0_rsp_valid(z_m0_rsp_valid), .o_m0_rsp_data(z_m0_rsp_data),
        .i_m1_valid(z_m1_valid), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
        .i_m1_wren(m1_wren), .i_m1_sel_mod(m1_sel),
        .o_m1_ready(z_m1_ready), .o_m1_rsp_valid(z_m1_rsp_valid), .o_m1_rsp_data(z_m1_rsp_data),
        .o_lsu_addr(z_lsu_addr), .o_lsu_st_data(z_lsu_st_data), .o_lsu_wren(z_lsu_wren),
        .o_lsu_sel_mod(z_lsu_sel), .i_lsu_ld_data(ld_data), .o_busy(z_busy)
    );

    task automatic test_reset();
        m0_valid = 1'b1; m1_valid = 1'b1; z_m0_valid = 1'b0; z_m1_valid = 1'b0;
        m0_addr = '0; m0_wdata = '0; m0_wren = 1'b0; m0_sel = '0;
        m1_addr = '0; m1_wdata = '0; m1_wren = 1'b0; m1_sel = '0; ld_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if ({m0_ready, m1_ready} !== 2'b00) begin
            err_cnt++; $display("FAIL reset_ready: got %b, required 00", {m0_ready, m1_ready});
        end
        vec_cnt++;
        if ({m0_rsp_valid, m1_rsp_valid, lsu_wren, busy} !== 4'b0000) begin
            err_cnt++; $display("FAIL reset_ctrl: got %b, required 0000", {m0_rsp_valid, m1_rsp_valid, lsu_wren, busy});
        end
        vec_cnt++;
        if ({m0_rsp_data, m1_rsp_data} !== 64'h0) begin
            err_cnt++; $display("FAIL reset_rsp_data: got %h %h, required 0", m0_rsp_data, m1_rsp_data);
        end
        vec_cnt++;
        if ({lsu_addr, lsu_st_data, lsu_sel} !== 67'h0) begin
            err_cnt++; $display("FAIL reset_lsu: got %h %h %h, required 0", lsu_addr, lsu_st_data, lsu_sel);
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_store();
        exp_t e;
        int   hs;
        @(posedge clk); #1;
        m0_addr = 32'h0000_0010; m0_wdata = 32'hDEAD_BEEF; m0_wren = 1'b1; m0_sel = 3'b010;
        m0_valid = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (m0_ready !== 1'b1) begin
            err_cnt++; $display("FAIL store_first_grant: got ready=%b, required 1", m0_ready);
        end
        hs = cyc;
        sb.push_back('{1'b0, 32'h0, hs + 2 + RD});
        @(posedge clk); #1;
        m0_valid = 1'b0;
        for (int k = 1; k <= 4 + RD; k++) begin
            @(negedge clk);
            vec_cnt++;
            if (lsu_wren !== (k == 1)) begin
                err_cnt++; $display("FAIL store_wren k=%0d: got %b, required %b", k, lsu_wren, (k == 1));
            end
            if (k == 1) begin
                vec_cnt++;
                if ({lsu_addr, lsu_st_data, lsu_sel} !== {32'h0000_0010, 32'hDEAD_BEEF, 3'b010}) begin
                    err_cnt++; $display("FAIL store_lsu: got %h %h %b, required 00000010 deadbeef 010", lsu_addr, lsu_st_data, lsu_sel);
                end
            end
            if (m0_rsp_valid || m1_rsp_valid) begin
                vec_cnt++;
                if (sb.size() == 0) begin
                    err_cnt++; $display("FAIL store_unexpected_rsp: got v0=%b v1=%b cyc=%0d, required none", m0_rsp_valid, m1_rsp_valid, cyc);
                end else begin
                    e = sb.pop_front();
                    if ({m1_rsp_valid, m0_rsp_valid, (e.id ? m1_rsp_data : m0_rsp_data), cyc} !== {e.id, ~e.id, e.data, e.due}) begin
                        err_cnt++; $display("FAIL store_rsp: got v1=%b v0=%b data=%h cyc=%0d, required id=%0d data=%h cyc=%0d", m1_rsp_valid, m0_rsp_valid, (e.id ? m1_rsp_data : m0_rsp_data), cyc, e.id, e.data, e.due);
                    end
                end
            end
        end
        vec_cnt++;
        if (sb.size() != 0) begin
            err_cnt++; $display("FAIL store_rsp_timeout: got %0d outstanding, required 0", sb.size()); sb.delete();
        end
    endtask

    task automatic test_m1_load();
        exp_t e;
        int   hs;
        @(posedge clk); #1;
        m1_addr = 32'h0000_0904; m1_wren = 1'b0; m1_sel = 3'b000; ld_data = 32'h0000_00A5;
        m1_valid = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if ({m1_ready, m0_ready} !== 2'b10) begin
            err_cnt++; $display("FAIL m1_grant: got %b, required 10", {m1_ready, m0_ready});
        end
        hs = cyc;
        sb.push_back('{1'b1, 32'h0000_00A5, hs + 2 + RD});
        @(posedge clk); #1;
        m1_valid = 1'b0;
        for (int k = 1; k <= 4 + RD; k++) begin
            @(negedge clk);
            if (k == 1) begin
                vec_cnt++;
                if ({lsu_addr, lsu_sel, lsu_wren} !== {32'h0000_0904, 3'b000, 1'b0}) begin
                    err_cnt++; $display("FAIL m1_lsu: got %h %b %b, required 00000904 000 0", lsu_addr, lsu_sel, lsu_wren);
                end
            end
            if (m0_rsp_valid || m1_rsp_valid) begin
                vec_cnt++;
                if (sb.size() == 0) begin
                    err_cnt++; $display("FAIL m1_unexpected_rsp: got v0=%b v1=%b cyc=%0d, required none", m0_rsp_valid, m1_rsp_valid, cyc);
                end else begin
                    e = sb.pop_front();
                    if ({m1_rsp_valid, m0_rsp_valid, (e.id ? m1_rsp_data : m0_rsp_data), cyc} !== {e.id, ~e.id, e.data, e.due}) begin
                        err_cnt++; $display("FAIL m1_rsp: got v1=%b v0=%b data=%h cyc=%0d, required id=%0d data=%h cyc=%0d", m1_rsp_valid, m0_rsp_valid, (e.id ? m1_rsp_data : m0_rsp_data), cyc, e.id, e.data, e.due);
                    end
                end
                vec_cnt++;
                if (m0_rsp_data !== 32'h0) begin
                    err_cnt++; $display("FAIL m0_rsp_hold: got %h, required 00000000", m0_rsp_data);
                end
            end
        end
        vec_cnt++;
        if (sb.size() != 0) begin
            err_cnt++; $display("FAIL m1_rsp_timeout: got %0d outstanding, required 0", sb.size()); sb.delete();
        end
    endtask

    task automatic test_arbitration();
        exp_t e;
        int   grants = 0;
        int   prev = -1;
        int   c = 0;
        logic exp_id;
        @(posedge clk); #1;
        m0_addr = 32'h0000_0100; m0_wren = 1'b0; m0_sel = 3'b010;
        m1_addr = 32'h0000_0200; m1_wren = 1'b0; m1_sel = 3'b010;
        ld_data = 32'h1357_9BDF;
        m0_valid = 1'b1; m1_valid = 1'b1;
        while (c < 4 * (3 + RD) + 8 && (grants < 4 || sb.size() > 0)) begin
            c++;
            @(negedge clk);
            vec_cnt++;
            if ((m0_ready || m1_ready) && busy) begin
                err_cnt++; $display("FAIL arb_ready_busy: got ready=%b%b busy=1, required ready 00", m1_ready, m0_ready);
            end
            if (m0_ready || m1_ready) begin
`ifdef LSU_ARB_RR_EN
                exp_id = grants[0];
`else
                exp_id = 1'b0;
`endif
                vec_cnt++;
                if ({m1_ready, m0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
                    err_cnt++; $display("FAIL arb_order #%0d: got %b, required %b", grants, {m1_ready, m0_ready}, (exp_id ? 2'b10 : 2'b01));
                end
                if (prev >= 0) begin
                    vec_cnt++;
                    if (cyc - prev !== 3 + RD) begin
                        err_cnt++; $display("FAIL arb_spacing #%0d: got %0d, required %0d", grants, cyc - prev, 3 + RD);
                    end
                end
                prev = cyc;
                sb.push_back('{exp_id, 32'h1357_9BDF, cyc + 2 + RD});
                grants++;
            end
            if (m0_rsp_valid || m1_rsp_valid) begin
                vec_cnt++;
                if (sb.size() == 0) begin
                    err_cnt++; $display("FAIL arb_unexpected_rsp: got v0=%b v1=%b cyc=%0d, required none", m0_rsp_valid, m1_rsp_valid, cyc);
                end else begin
                    e = sb.pop_front();
                    if ({m1_rsp_valid, m0_rsp_valid, (e.id ? m1_rsp_data : m0_rsp_data), cyc} !== {e.id, ~e.id, e.data, e.due}) begin
                        err_cnt++; $display("FAIL arb_rsp: got v1=%b v0=%b data=%h cyc=%0d, required id=%0d data=%h cyc=%0d", m1_rsp_valid, m0_rsp_valid, (e.id ? m1_rsp_data : m0_rsp_data), cyc, e.id, e.data, e.due);
                    end
                end
            end
            if (grants == 4 && (m0_valid || m1_valid)) begin
                @(posedge clk); #1;
                m0_valid = 1'b0; m1_valid = 1'b0;
            end
        end
        vec_cnt++;
        if (grants != 4 || sb.size() != 0) begin
            err_cnt++; $display("FAIL arb_incomplete: got grants=%0d outstanding=%0d, required 4 and 0", grants, sb.size()); sb.delete();
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
    endtask

    task automatic test_busy_wait();
        exp_t e;
        int   hs0;
        int   c = 0;
        bit   granted = 0;
        @(posedge clk); #1;
        m0_addr = 32'h0000_0300; m0_wren = 1'b0; m0_sel = 3'b010; ld_data = 32'h2468_ACE0;
        m0_valid = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (m0_ready !== 1'b1) begin
            err_cnt++; $display("FAIL busy_m0_grant: got %b, required 1", m0_ready);
        end
        hs0 = cyc;
        sb.push_back('{1'b0, 32'h2468_ACE0, hs0 + 2 + RD});
        @(posedge clk); #1;
        m0_valid = 1'b0;
        @(posedge clk); #1;
        m1_addr = 32'h0000_0400; m1_wdata = 32'h0BAD_F00D; m1_wren = 1'b1; m1_sel = 3'b001;
        m1_valid = 1'b1;
        while (c < 16 && !(granted && sb.size() == 0)) begin
            c++;
            @(negedge clk);
            if (!granted && cyc < hs0 + 3 + RD) begin
                vec_cnt++;
                if ({m1_ready, busy} !== 2'b01) begin
                    err_cnt++; $display("FAIL busy_wait_ready cyc=%0d: got ready=%b busy=%b, required 0 1", cyc, m1_ready, busy);
                end
            end else if (!granted) begin
                vec_cnt++;
                if (m1_ready !== 1'b1 || cyc !== hs0 + 3 + RD) begin
                    err_cnt++; $display("FAIL busy_m1_grant: got ready=%b at cyc=%0d, required 1 at %0d", m1_ready, cyc, hs0 + 3 + RD);
                end
                if (m1_ready) begin
                    sb.push_back('{1'b1, 32'h0, cyc + 2 + RD});
                    granted = 1;
                end
            end
            if (m0_rsp_valid || m1_rsp_valid) begin
                vec_cnt++;
                if (sb.size() == 0) begin
                    err_cnt++; $display("FAIL busy_unexpected_rsp: got v0=%b v1=%b cyc=%0d, required none", m0_rsp_valid, m1_rsp_valid, cyc);
                end else begin
                    e = sb.pop_front();
                    if ({m1_rsp_valid, m0_rsp_valid, (e.id ? m1_rsp_data : m0_rsp_data), cyc} !== {e.id, ~e.id, e.data, e.due}) begin
                        err_cnt++; $display("FAIL busy_rsp: got v1=%b v0=%b data=%h cyc=%0d, required id=%0d data=%h cyc=%0d", m1_rsp_valid, m0_rsp_valid, (e.id ? m1_rsp_data : m0_rsp_data), cyc, e.id, e.data, e.due);
                    end
                end
            end
            if (granted && m1_valid) begin
                @(posedge clk); #1;
                m1_valid = 1'b0;
            end
        end
        vec_cnt++;
        if (!granted || sb.size() != 0) begin
            err_cnt++; $display("FAIL busy_incomplete: got granted=%0d outstanding=%0d, required 1 and 0", granted, sb.size()); sb.delete();
        end
        m1_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   hs;
        @(posedge clk); #1;
        m0_addr = 32'h0000_0500; m0_wren = 1'b0; m0_sel = 3'b010; ld_data = 32'hCAFE_0000;
        m0_valid = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (m0_ready !== 1'b1) begin
            err_cnt++; $display("FAIL rstmid_grant: got %b, required 1", m0_ready);
        end
        @(posedge clk); #1;
        m0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b1) begin
            err_cnt++; $display("FAIL rstmid_busy_before: got %b, required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({lsu_wren, busy, m0_ready, m1_ready, m0_rsp_valid, m1_rsp_valid} !== 6'b0) begin
            err_cnt++; $display("FAIL rstmid_ctrl: got %b, required 000000", {lsu_wren, busy, m0_ready, m1_ready, m0_rsp_valid, m1_rsp_valid});
        end
        vec_cnt++;
        if ({lsu_addr, lsu_st_data, lsu_sel, m0_rsp_data, m1_rsp_data} !== 131'h0) begin
            err_cnt++; $display("FAIL rstmid_data: got %h %h %b %h %h, required 0", lsu_addr, lsu_st_data, lsu_sel, m0_rsp_data, m1_rsp_data);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vec_cnt++;
            if ({m0_rsp_valid, m1_rsp_valid, busy} !== 3'b000) begin
                err_cnt++; $display("FAIL rstmid_hold k=%0d: got %b, required 000", k, {m0_rsp_valid, m1_rsp_valid, busy});
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        m0_addr = 32'h0000_0020; ld_data = 32'h0000_0000;
        m1_addr = 32'h0000_0600; m1_wren = 1'b0; m1_sel = 3'b010;
        m0_valid = 1'b1; m1_valid = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if ({m1_ready, m0_ready} !== 2'b01) begin
            err_cnt++; $display("FAIL rstmid_post_grant: got %b, required 01", {m1_ready, m0_ready});
        end
        hs = cyc;
        sb.push_back('{1'b0, 32'h0, hs + 2 + RD});
        @(posedge clk); #1;
        m0_valid = 1'b0; m1_valid = 1'b0;
        for (int k = 1; k <= 4 + RD; k++) begin
            @(negedge clk);
            if (m0_rsp_valid || m1_rsp_valid) begin
                vec_cnt++;
                if (sb.size() == 0) begin
                    err_cnt++; $display("FAIL rstmid_unexpected_rsp: got v0=%b v1=%b cyc=%0d, required none", m0_rsp_valid, m1_rsp_valid, cyc);
                end else begin
                    e = sb.pop_front();
                    if ({m1_rsp_valid, m0_rsp_valid, (e.id ? m1_rsp_data : m0_rsp_data), cyc} !== {e.id, ~e.id, e.data, e.due}) begin
                        err_cnt++; $display("FAIL rstmid_rsp: got v1=%b v0=%b data=%h cyc=%0d, required id=%0d data=%h cyc=%0d", m1_rsp_valid, m0_rsp_valid, (e.id ? m1_rsp_data : m0_rsp_data), cyc, e.id, e.data, e.due);
                    end
                end
            end
        end
        vec_cnt++;
        if (sb.size() != 0) begin
            err_cnt++; $display("FAIL rstmid_rsp_timeout: got %0d outstanding, required 0", sb.size()); sb.delete();
        end
    endtask

    task automatic test_rd_lat0();
        exp_t e;
        int   grants = 0;
        int   prev = -1;
        int   c = 0;
        @(posedge clk); #1;
        m0_addr = 32'h0000_0700; m0_wren = 1'b0; m0_sel = 3'b010; ld_data = 32'h8765_4321;
        z_m0_valid = 1'b1;
        while (c < 16 && !(grants == 2 && sb.size() == 0)) begin
            c++;
            @(negedge clk);
            vec_cnt++;
            if ({z_m1_ready, z_m1_rsp_valid, z_m1_rsp_data} !== 34'h0) begin
                err_cnt++; $display("FAIL lat0_m1_idle: got %b %b %h, required 0", z_m1_ready, z_m1_rsp_valid, z_m1_rsp_data);
            end
            if (grants == 2 && cyc == prev + 1) begin
                vec_cnt++;
                if ({z_lsu_wren, z_lsu_addr, z_lsu_st_data, z_lsu_sel} !== {1'b1, 32'h0000_0704, 32'h55AA_55AA, 3'b010}) begin
                    err_cnt++; $display("FAIL lat0_store_lsu: got %b %h %h %b, required 1 00000704 55aa55aa 010", z_lsu_wren, z_lsu_addr, z_lsu_st_data, z_lsu_sel);
                end
            end
            if (grants == 2 && cyc == prev + 3) begin
                vec_cnt++;
                if (z_busy !== 1'b0) begin
                    err_cnt++; $display("FAIL lat0_busy_end: got %b, required 0", z_busy);
                end
            end
            if (z_m0_valid && z_m0_ready) begin
                if (prev >= 0) begin
                    vec_cnt++;
                    if (cyc - prev !== 3) begin
                        err_cnt++; $display("FAIL lat0_spacing: got %0d, required 3", cyc - prev);
                    end
                end
                prev = cyc;
                sb.push_back('{1'b0, (grants == 0) ? 32'h8765_4321 : 32'h0, cyc + 2});
                grants++;
            end
            if (z_m0_rsp_valid || z_m1_rsp_valid) begin
                vec_cnt++;
                if (sb.size() == 0) begin
                    err_cnt++; $display("FAIL lat0_unexpected_rsp: got v0=%b v1=%b cyc=%0d, required none", z_m0_rsp_valid, z_m1_rsp_valid, cyc);
                end else begin
                    e = sb.pop_front();
                    if ({z_m1_rsp_valid, z_m0_rsp_valid, z_m0_rsp_data, cyc} !== {e.id, ~e.id, e.data, e.due}) begin
                        err_cnt++; $display("FAIL lat0_rsp: got v1=%b v0=%b data=%h cyc=%0d, required id=%0d data=%h cyc=%0d", z_m1_rsp_valid, z_m0_rsp_valid, z_m0_rsp_data, cyc, e.id, e.data, e.due);
                    end
                end
            end
            if (z_m0_valid && z_m0_ready) begin
                @(posedge clk); #1;
                if (grants == 1) begin
                    m0_addr = 32'h0000_0704; m0_wdata = 32'h55AA_55AA; m0_wren = 1'b1;
                end else begin
                    z_m0_valid = 1'b0;
                end
            end
        end
        vec_cnt++;
        if (grants != 2 || sb.size() != 0) begin
            err_cnt++; $display("FAIL lat0_incomplete: got grants=%0d outstanding=%0d, required 2 and 0", grants, sb.size()); sb.delete();
        end
        z_m0_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_store();
        test_m1_load();
        test_arbitration();
        test_busy_wait();
        test_reset_mid();
        test_rd_lat0();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
